io_scan_sequencer: RTL and testbench



---
 rtl/io_scan_sequencer.sv | 163 ++++++++++++++++
 tb/tb_io_scan_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_scan_sequencer.sv
// Steps a bank of IO pins through test patterns, one step per DWELL_TICKS divider ticks.
// Define IO_SCAN_PINGPONG_EN to get an up/down sweep instead of a wrapping one.
module io_scan_sequencer #(
  parameter int unsigned NUM_PINS    = 20,
  parameter int unsigned DWELL_TICKS = 1,
  parameter int unsigned PASSES      = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        tick,
  input  logic                        start,
  input  logic                        stop,
  input  logic [1:0]                  mode,
  output logic [NUM_PINS-1:0]         io_out,
  output logic [$clog2(NUM_PINS)-1:0] pin_index,
  output logic [7:0]                  pass_count,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned IdxW = $clog2(NUM_PINS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_PINS - 1);
  localparam logic [7:0] DwellLast  = 8'(DWELL_TICKS - 1);
  localparam logic [7:0] PassTarget = 8'(PASSES);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e              state_q;
  logic [7:0]          dwell_q;
  logic [IdxW-1:0]     pin_index_q;
  logic [IdxW-1:0]     pin_index_d;
  logic [7:0]          pass_count_q;
  logic [7:0]          pass_inc;
  logic [NUM_PINS-1:0] io_out_q;
  logic                busy_q;
  logic                done_q;
  logic                step;
  logic                pass_wrap;
  logic                finish;
`ifdef IO_SCAN_PINGPONG_EN
  logic                dir_q;  // 0 = counting up, 1 = counting down
  logic                dir_d;
`endif

  function automatic logic [NUM_PINS-1:0] pattern(input logic [IdxW-1:0] idx,
                                                  input logic [1:0]      m);
    logic [NUM_PINS-1:0] pat;
    pat = '0;
    for (int unsigned b = 0; b < NUM_PINS; b++) begin
      case (m)
        2'd0:    pat[b] = (IdxW'(b) == idx);
        2'd1:    pat[b] = (IdxW'(b) != idx);
        2'd2:    pat[b] = idx[0];
        default: pat[b] = (IdxW'(b) <= idx);
      endcase
    end
    return pat;
  endfunction

  always_comb begin
    step     = tick && (dwell_q == DwellLast);
    pass_inc = (pass_count_q == 8'hFF) ? 8'hFF : pass_count_q + 8'd1;
`ifdef IO_SCAN_PINGPONG_EN
    dir_d     = dir_q;
    pass_wrap = 1'b0;
    if (!dir_q) begin
      if (pin_index_q == LastIdx) begin
        dir_d       = 1'b1;
        pin_index_d = pin_index_q - IdxW'(1);
      end else begin
        pin_index_d = pin_index_q + IdxW'(1);
      end
    end else begin
      pin_index_d = pin_index_q - IdxW'(1);
      // Reaching 0 on the way down closes a pass.
      if (pin_index_q == IdxW'(1)) begin
        dir_d     = 1'b0;
        pass_wrap = 1'b1;
      end
    end
`else
    pass_wrap   = (pin_index_q == LastIdx);
    pin_index_d = pass_wrap ? '0 : pin_index_q + IdxW'(1);
`endif
    finish = pass_wrap && (PASSES != 0) && (pass_inc == PassTarget);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      dwell_q      <= '0;
      pin_index_q  <= '0;
      pass_count_q <= '0;
      io_out_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef IO_SCAN_PINGPONG_EN
      dir_q        <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          io_out_q <= '0;
          busy_q   <= 1'b0;
          if (start && !stop) begin
            state_q      <= StScan;
            busy_q       <= 1'b1;
            dwell_q      <= '0;
            pin_index_q  <= '0;
            pass_count_q <= '0;
`ifdef IO_SCAN_PINGPONG_EN
            dir_q        <= 1'b0;
`endif
          end
        end
        StScan: begin
          if (stop) begin
            // Abort wins over a coincident tick; index and pass count are held.
            state_q  <= StIdle;
            busy_q   <= 1'b0;
            io_out_q <= '0;
          end else begin
            io_out_q <= pattern(pin_index_q, mode);
            if (step) begin
              dwell_q     <= '0;
              pin_index_q <= pin_index_d;
`ifdef IO_SCAN_PINGPONG_EN
              dir_q       <= dir_d;
`endif
              if (pass_wrap) begin
                pass_count_q <= pass_inc;
              end
              if (finish) begin
                state_q  <= StDone;
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
                io_out_q <= '0;
              end
            end else if (tick) begin
              dwell_q <= dwell_q + 8'd1;
            end
          end
        end
        StDone: begin
          state_q  <= StIdle;
          busy_q   <= 1'b0;
          io_out_q <= '0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign io_out     = io_out_q;
  assign pin_index  = pin_index_q;
  assign pass_count = pass_count_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_io_scan_sequencer.sv
// Directed bench for io_scan_sequencer: three 4-pin instances sharing stimulus
// (a: PASSES=1, b: DWELL_TICKS=3, c: free-running).
module tb_io_scan_sequencer;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       start;
  logic       stop;
  logic [1:0] mode;

  logic [3:0] io_a, io_b, io_c;
  logic [1:0] idx_a, idx_b, idx_c;
  logic [7:0] pc_a, pc_b, pc_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;

  int n_vec;
  int n_miss;

`ifdef IO_SCAN_PINGPONG_EN
  localparam int PpSteps = 6;
  int pp_exp[6] = '{1, 2, 3, 2, 1, 0};
`else
  localparam int PpSteps = 4;
  int pp_exp[4] = '{1, 2, 3, 0};
`endif

  io_scan_sequencer #(.NUM_PINS(4), .DWELL_TICKS(1), .PASSES(1)) u_a (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .stop(stop), .mode(mode),
    .io_out(io_a), .pin_index(idx_a), .pass_count(pc_a), .busy(busy_a), .done(done_a)
  );

  io_scan_sequencer #(.NUM_PINS(4), .DWELL_TICKS(3), .PASSES(0)) u_b (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .stop(stop), .mode(mode),
    .io_out(io_b), .pin_index(idx_b), .pass_count(pc_b), .busy(busy_b), .done(done_b)
  );

  io_scan_sequencer #(.NUM_PINS(4), .DWELL_TICKS(1), .PASSES(0)) u_c (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .stop(stop), .mode(mode),
    .io_out(io_c), .pin_index(idx_c), .pass_count(pc_c), .busy(busy_c), .done(done_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick  = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    mode  = 2'd0;
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic start_pulse();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic tick_pulse();
    tick = 1'b1;
    cycle();
    tick = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({io_a, idx_a, pc_a, busy_a, done_a} !== 16'h0) begin
      n_miss++;
      $display("FAIL reset_a: got io=%b idx=%0d pc=%0d busy=%b done=%b, want all zero",
               io_a, idx_a, pc_a, busy_a, done_a);
    end
    n_vec++;
    if ({io_c, idx_c, pc_c, busy_c, done_c} !== 16'h0) begin
      n_miss++;
      $display("FAIL reset_c: got io=%b idx=%0d pc=%0d busy=%b done=%b, want all zero",
               io_c, idx_c, pc_c, busy_c, done_c);
    end
    tick_pulse();
    n_vec++;
    if ({idx_c, busy_c, io_c} !== 7'h0) begin
      n_miss++;
      $display("FAIL tick_in_idle: got idx=%0d busy=%b io=%b, want 0 0 0000", idx_c, busy_c, io_c);
    end
  endtask

  task automatic test_walk_one();
    logic [3:0] exp;
    int rem;
    do_reset();
    start_pulse();
    n_vec++;
    if (busy_a !== 1'b1 || io_a !== 4'b0000) begin
      n_miss++;
      $display("FAIL walk_enter: got busy=%b io=%b, want 1 0000", busy_a, io_a);
    end
    cycle();
    n_vec++;
    if (io_a !== 4'b0001 || idx_a !== 2'd0) begin
      n_miss++;
      $display("FAIL walk_step0: got io=%b idx=%0d, want 0001 0", io_a, idx_a);
    end
    for (int k = 1; k <= 3; k++) begin
      tick_pulse();
      exp = 4'b0001 << k;
      n_vec++;
      if (io_a !== exp || idx_a !== 2'(k)) begin
        n_miss++;
        $display("FAIL walk_step%0d: got io=%b idx=%0d, want %b %0d", k, io_a, idx_a, exp, k);
      end
    end
    rem = PpSteps - 3;
    for (int k = 0; k < rem; k++) begin
      tick = 1'b1;
      cycle();
      tick = 1'b0;
      if (k != rem - 1) cycle();
    end
    n_vec++;
    if (done_a !== 1'b1 || busy_a !== 1'b0 || io_a !== 4'b0000 || pc_a !== 8'd1) begin
      n_miss++;
      $display("FAIL walk_done: got done=%b busy=%b io=%b pc=%0d, want 1 0 0000 1",
               done_a, busy_a, io_a, pc_a);
    end
    start_pulse();
    n_vec++;
    if (done_a !== 1'b0 || busy_a !== 1'b0 || pc_a !== 8'd1) begin
      n_miss++;
      $display("FAIL done_one_cycle: got done=%b busy=%b pc=%0d, want 0 0 1", done_a, busy_a, pc_a);
    end
    cycle();
    n_vec++;
    if (busy_a !== 1'b0 || idx_a !== 2'd0) begin
      n_miss++;
      $display("FAIL start_in_done: got busy=%b idx=%0d, want 0 0", busy_a, idx_a);
    end
  endtask

  task automatic test_dwell();
    logic [3:0] exp;
    do_reset();
    start_pulse();
    cycle();
    for (int t = 1; t <= 9; t++) begin
      tick = 1'b1;
      cycle();
      tick = 1'b0;
      n_vec++;
      if (idx_b !== 2'(t / 3)) begin
        n_miss++;
        $display("FAIL dwell_idx_t%0d: got %0d, want %0d", t, idx_b, t / 3);
      end
      if (t % 3 == 0) begin
        exp = 4'b0001 << (t / 3 - 1);
        n_vec++;
        if (io_b !== exp) begin
          n_miss++;
          $display("FAIL dwell_lag_t%0d: got io=%b, want %b", t, io_b, exp);
        end
      end
      cycle();
      exp = 4'b0001 << (t / 3);
      n_vec++;
      if (io_b !== exp) begin
        n_miss++;
        $display("FAIL dwell_io_t%0d: got io=%b, want %b", t, io_b, exp);
      end
    end
  endtask

  task automatic test_stop_priority();
    do_reset();
    start_pulse();
    for (int k = 0; k < 6; k++) tick_pulse();
    n_vec++;
    if (idx_c !== 2'd2 || pc_c !== 8'd1) begin
      n_miss++;
      $display("FAIL free_run: got idx=%0d pc=%0d, want 2 1", idx_c, pc_c);
    end
    tick = 1'b1;
    stop = 1'b1;
    cycle();
    tick = 1'b0;
    stop = 1'b0;
    n_vec++;
    if (busy_c !== 1'b0 || idx_c !== 2'd2 || done_c !== 1'b0 || io_c !== 4'b0000 ||
        pc_c !== 8'd1) begin
      n_miss++;
      $display("FAIL stop_tick: got busy=%b idx=%0d done=%b io=%b pc=%0d, want 0 2 0 0000 1",
               busy_c, idx_c, done_c, io_c, pc_c);
    end
    cycle();
    n_vec++;
    if (done_c !== 1'b0 || idx_c !== 2'd2 || busy_c !== 1'b0) begin
      n_miss++;
      $display("FAIL stop_hold: got done=%b idx=%0d busy=%b, want 0 2 0", done_c, idx_c, busy_c);
    end
    start_pulse();
    n_vec++;
    if (idx_c !== 2'd0 || pc_c !== 8'd0 || busy_c !== 1'b1) begin
      n_miss++;
      $display("FAIL restart: got idx=%0d pc=%0d busy=%b, want 0 0 1", idx_c, pc_c, busy_c);
    end
  endtask

  task automatic test_start_controls();
    do_reset();
    start = 1'b1;
    stop  = 1'b1;
    cycle();
    n_vec++;
    if (busy_c !== 1'b0) begin
      n_miss++;
      $display("FAIL start_stop_idle: got busy=%b, want 0", busy_c);
    end
    start = 1'b0;
    stop  = 1'b0;
    cycle();
    n_vec++;
    if (busy_c !== 1'b0) begin
      n_miss++;
      $display("FAIL start_stop_idle2: got busy=%b, want 0", busy_c);
    end
    start_pulse();
    tick_pulse();
    tick_pulse();
    start_pulse();
    n_vec++;
    if (idx_c !== 2'd2 || pc_c !== 8'd0 || busy_c !== 1'b1) begin
      n_miss++;
      $display("FAIL start_busy: got idx=%0d pc=%0d busy=%b, want 2 0 1", idx_c, pc_c, busy_c);
    end
  endtask

  task automatic test_modes();
    logic [3:0] exp_io[4] = '{4'b0010, 4'b1101, 4'b1111, 4'b0011};
    do_reset();
    start_pulse();
    tick_pulse();
    for (int m = 0; m < 4; m++) begin
      mode = 2'(m);
      cycle();
      n_vec++;
      if (io_c !== exp_io[m] || idx_c !== 2'd1) begin
        n_miss++;
        $display("FAIL mode%0d_idx1: got io=%b idx=%0d, want %b 1", m, io_c, idx_c, exp_io[m]);
      end
    end
    mode = 2'd2;
    tick_pulse();
    n_vec++;
    if (io_c !== 4'b0000 || idx_c !== 2'd2) begin
      n_miss++;
      $display("FAIL flash_idx2: got io=%b idx=%0d, want 0000 2", io_c, idx_c);
    end
    mode = 2'd3;
    cycle();
    n_vec++;
    if (io_c !== 4'b0111) begin
      n_miss++;
      $display("FAIL fill_idx2: got io=%b, want 0111", io_c);
    end
    mode = 2'd0;
  endtask

  task automatic test_pingpong();
    do_reset();
    start_pulse();
    for (int n = 0; n < PpSteps; n++) begin
      tick = 1'b1;
      cycle();
      tick = 1'b0;
      n_vec++;
      if (n < PpSteps - 1) begin
        if (idx_a !== 2'(pp_exp[n]) || done_a !== 1'b0 || busy_a !== 1'b1) begin
          n_miss++;
          $display("FAIL sweep_step%0d: got idx=%0d done=%b busy=%b, want %0d 0 1",
                   n + 1, idx_a, done_a, busy_a, pp_exp[n]);
        end
        cycle();
      end else begin
        if (done_a !== 1'b1 || idx_a !== 2'd0 || pc_a !== 8'd1) begin
          n_miss++;
          $display("FAIL sweep_done: got done=%b idx=%0d pc=%0d, want 1 0 1", done_a, idx_a, pc_a);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    start_pulse();
    for (int k = 0; k < 5; k++) tick_pulse();
    n_vec++;
    if (busy_c !== 1'b1 || pc_c !== 8'd1 || idx_c !== 2'd1 || io_c !== 4'b0010) begin
      n_miss++;
      $display("FAIL pre_reset: got busy=%b pc=%0d idx=%0d io=%b, want 1 1 1 0010",
               busy_c, pc_c, idx_c, io_c);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({io_c, idx_c, pc_c, busy_c, done_c} !== 16'h0) begin
      n_miss++;
      $display("FAIL async_reset: got io=%b idx=%0d pc=%0d busy=%b done=%b, want all zero",
               io_c, idx_c, pc_c, busy_c, done_c);
    end
    rst_n = 1'b1;
    cycle();
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    test_reset();
    test_walk_one();
    test_dwell();
    test_stop_priority();
    test_start_controls();
    test_modes();
    test_pingpong();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
